// File: rtl/hp2vga_pkg.sv
// Shared definitions for the HP video capture path: sequencer states,
// default capture geometry and a counter-width helper.
package hp2vga_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LINE = 3'd1,
    ST_SKIP      = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_LINE_END  = 3'd4
  } cap_state_e;

  localparam int DEF_H_PIXELS = 512;
  localparam int DEF_V_LINES  = 342;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hp_sync_edge.sv
// One-register rising-edge detector for an already-synchronous strobe.
module hp_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_reg <= 1'b0;
    else        sig_reg <= sig;
  end

  assign rise = sig & ~sig_reg;

endmodule

// File: rtl/hp_capture_ctrl.sv
// Capture sequencer: turns buffered HSYNC/VSYNC/pixel into decimated frame-store writes.
// Define HP_CAPTURE_ERR_COUNT_EN to count short lines and frame aborts on err_count.
module hp_capture_ctrl
  import hp2vga_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int H_PIXELS   = DEF_H_PIXELS,
  parameter int V_LINES    = DEF_V_LINES,
  parameter int H_OFFSET   = 16,
  parameter int SAMPLE_DIV = 2,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic [DATA_WIDTH-1:0] pixel,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  frame_done,
  output logic                  locked,
  output logic [7:0]            err_count
);

  localparam int COL_W  = cnt_width(H_PIXELS);
  localparam int ROW_W  = cnt_width(V_LINES);
  localparam int SKIP_W = cnt_width(H_OFFSET);
  localparam int DIV_W  = cnt_width(SAMPLE_DIV);

  cap_state_e            state_reg, state_next;
  logic [ROW_W-1:0]      row_reg, row_next;
  logic [COL_W-1:0]      col_reg, col_next;
  logic [SKIP_W-1:0]     skip_reg, skip_next;
  logic [DIV_W-1:0]      div_reg, div_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0] line_start_reg, line_start_next;
  logic                  wr_en_reg, wr_en_next;
  logic [ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
  logic [DATA_WIDTH-1:0] wr_data_reg, wr_data_next;
  logic                  frame_done_reg, frame_done_next;
  logic                  locked_reg, locked_next;
  logic                  err_inc;
  logic                  h_rise, v_rise;
  logic                  final_line_end;

  hp_sync_edge u_hsync_edge (.clk(clk), .rst_n(rst_n), .sig(hsync), .rise(h_rise));
  hp_sync_edge u_vsync_edge (.clk(clk), .rst_n(rst_n), .sig(vsync), .rise(v_rise));

  assign final_line_end = (state_reg == ST_LINE_END) && (row_reg == ROW_W'(V_LINES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      row_reg        <= '0;
      col_reg        <= '0;
      skip_reg       <= '0;
      div_reg        <= '0;
      addr_reg       <= '0;
      line_start_reg <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      frame_done_reg <= 1'b0;
      locked_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      row_reg        <= row_next;
      col_reg        <= col_next;
      skip_reg       <= skip_next;
      div_reg        <= div_next;
      addr_reg       <= addr_next;
      line_start_reg <= line_start_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      frame_done_reg <= frame_done_next;
      locked_reg     <= locked_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    row_next        = row_reg;
    col_next        = col_reg;
    skip_next       = skip_reg;
    div_next        = div_reg;
    addr_next       = addr_reg;
    line_start_next = line_start_reg;
    wr_en_next      = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    frame_done_next = 1'b0;
    locked_next     = locked_reg;
    err_inc         = 1'b0;

    case (state_reg)
      ST_WAIT_LINE: begin
        if (h_rise) begin
          state_next = ST_SKIP;
          skip_next  = SKIP_W'(H_OFFSET);
        end
      end
      ST_SKIP: begin
        // Leaving one count early lines the first write up H_OFFSET+1 clocks after the edge.
        if (skip_reg <= SKIP_W'(1)) begin
          state_next = ST_CAPTURE;
          col_next   = '0;
          div_next   = '0;
        end else begin
          skip_next = skip_reg - 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (col_reg == COL_W'(H_PIXELS)) begin
          state_next = ST_LINE_END;
        end else if (h_rise) begin
          // Short line: rewrite this row from its first address.
          state_next  = ST_SKIP;
          skip_next   = SKIP_W'(H_OFFSET);
          addr_next   = line_start_reg;
          locked_next = 1'b0;
          err_inc     = 1'b1;
        end else begin
          if (div_reg == '0) begin
            wr_en_next   = 1'b1;
            wr_addr_next = addr_reg;
            wr_data_next = pixel;
            addr_next    = addr_reg + 1'b1;
            col_next     = col_reg + 1'b1;
          end
          div_next = (div_reg == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_reg + 1'b1;
        end
      end
      ST_LINE_END: begin
        if (final_line_end) begin
          state_next      = ST_IDLE;
          frame_done_next = 1'b1;
          locked_next     = 1'b1;
          row_next        = '0;
          addr_next       = '0;
          line_start_next = '0;
        end else begin
          state_next      = ST_WAIT_LINE;
          row_next        = row_reg + 1'b1;
          line_start_next = addr_reg;
        end
      end
      default: ;
    endcase

    // Frame sync overrides everything; a coincident line edge starts row 0 at once.
    if (v_rise) begin
      if (state_reg != ST_IDLE && !final_line_end) begin
        locked_next = 1'b0;
        err_inc     = 1'b1;
      end
      wr_en_next      = 1'b0;
      wr_addr_next    = wr_addr_reg;
      wr_data_next    = wr_data_reg;
      row_next        = '0;
      col_next        = '0;
      div_next        = '0;
      addr_next       = '0;
      line_start_next = '0;
      state_next      = h_rise ? ST_SKIP : ST_WAIT_LINE;
      skip_next       = h_rise ? SKIP_W'(H_OFFSET) : skip_reg;
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign frame_done = frame_done_reg;
  assign locked     = locked_reg;

`ifdef HP_CAPTURE_ERR_COUNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              err_cnt_reg <= '0;
    else if (err_inc && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
  end

  assign err_count = err_cnt_reg;
`else
  logic unused_err_inc;
  assign unused_err_inc = err_inc;
  assign err_count      = 8'd0;
`endif

endmodule

// File: tb/tb_hp_capture_ctrl.sv
// Bench for hp_capture_ctrl on a 4x3 geometry: random pixels and gaps, expected
// writes derived from line-start edges and row*H_PIXELS+col addressing.
module tb_hp_capture_ctrl;

  localparam int DW = 9;
  localparam int HP = 4;
  localparam int VL = 3;
  localparam int HO = 2;
  localparam int SD = 2;
  localparam int AW = 8;

  typedef struct packed {
    int e;
    int a;
    int d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hsync = 1'b0;
  logic          vsync = 1'b0;
  logic [DW-1:0] pixel = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_done;
  logic          locked;
  logic [7:0]    err_count;

  hp_capture_ctrl #(
    .DATA_WIDTH(DW), .H_PIXELS(HP), .V_LINES(VL),
    .H_OFFSET(HO), .SAMPLE_DIV(SD), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .pixel(pixel),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int  edge_cnt = 0;
  int  tests = 0;
  int  fails = 0;
  wr_t act_q[$];
  wr_t exp_q[$];
  int  fd_q[$];
  int  exp_fd_q[$];
  wr_t mon_w;

  // Abstract model state
  bit       m_in_frame = 0;
  bit       m_locked = 0;
  bit       m_pending_short = 0;
  int       m_row = 0;
  int       m_err = 0;
  bit       pix_const = 0;
  bit [8:0] pix_seed = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      mon_w.e = edge_cnt;
      mon_w.a = int'(wr_addr);
      mon_w.d = int'(wr_data);
      act_q.push_back(mon_w);
      $display("[TB] write edge=%0d addr=%0d data=%03h", edge_cnt, wr_addr, wr_data);
    end
    if (rst_n && frame_done) begin
      fd_q.push_back(edge_cnt);
      $display("[TB] frame_done edge=%0d", edge_cnt);
    end
  end

  function automatic logic [DW-1:0] pix_at(input int e);
    logic [31:0] v;
    v = 32'(e) * 32'd37;
    return pix_const ? 9'h1C9 : (v[8:0] ^ pix_seed);
  endfunction

  function automatic int exp_err();
`ifdef HP_CAPTURE_ERR_COUNT_EN
    return (m_err > 255) ? 255 : m_err;
`else
    return 0;
`endif
  endfunction

  task automatic cyc(input bit h, input bit v);
    hsync = h;
    vsync = v;
    pixel = pix_at(edge_cnt + 1);
    @(negedge clk);
  endtask

  task automatic clear_queues();
    act_q.delete(); exp_q.delete(); fd_q.delete(); exp_fd_q.delete();
  endtask

  task automatic start_frame();
    if (m_in_frame) begin m_err++; m_locked = 0; end
    m_in_frame = 1; m_row = 0; m_pending_short = 0;
    cyc(0, 1);
    cyc(0, 0);
  endtask

  // One line: HSYNC edge (optionally with VSYNC), npix captured pixels; a full
  // line also runs through its end-of-line clocks and an optional VSYNC there.
  task automatic line(input int npix, input bit with_v, input bit v_at_end);
    int  n, last;
    bit  cap;
    wr_t w;
    n = edge_cnt + 1;
    if (with_v) begin
      if (m_in_frame) begin m_err++; m_locked = 0; end
      m_in_frame = 1; m_row = 0; m_pending_short = 0;
    end else if (m_pending_short && m_in_frame) begin
      m_err++; m_locked = 0; m_pending_short = 0;
    end
    cap = m_in_frame;
    if (cap) begin
      for (int k = 0; k < npix; k++) begin
        w.e = n + 1 + HO + k * SD;
        w.a = m_row * HP + k;
        w.d = int'(pix_at(w.e));
        exp_q.push_back(w);
      end
    end
    last = n + 1 + HO + (npix - 1) * SD;
    cyc(1, with_v);
    while (edge_cnt < last) cyc(0, 0);
    if (npix < HP) begin
      m_pending_short = cap;
    end else begin
      cyc(0, 0);
      if (cap) begin
        m_row++;
        if (m_row == VL) begin
          exp_fd_q.push_back(edge_cnt + 1);
          m_locked = 1; m_in_frame = 0; m_row = 0;
        end
      end
      cyc(0, v_at_end);
      if (v_at_end) begin
        if (m_in_frame) begin m_err++; m_locked = 0; end
        m_in_frame = 1; m_row = 0;
      end
      repeat ($urandom_range(0, 2)) cyc(0, 0);
    end
  endtask

  task automatic test_reset();
    repeat (3) cyc(0, 0);
    #1;
    tests++; if (wr_en !== 1'b0)      begin fails++; $display("FAIL reset wr_en: got %b expected 0", wr_en); end
    tests++; if (wr_addr !== '0)      begin fails++; $display("FAIL reset wr_addr: got %0d expected 0", wr_addr); end
    tests++; if (wr_data !== '0)      begin fails++; $display("FAIL reset wr_data: got %0h expected 0", wr_data); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset frame_done: got %b expected 0", frame_done); end
    tests++; if (locked !== 1'b0)     begin fails++; $display("FAIL reset locked: got %b expected 0", locked); end
    tests++; if (err_count !== 8'd0)  begin fails++; $display("FAIL reset err_count: got %0d expected 0", err_count); end
    rst_n = 1'b1;
    repeat (3) cyc(0, 0);
    #1;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL post_reset wr_en: got %b expected 0", wr_en); end
  endtask

  task automatic test_clean_frame();
    clear_queues();
    pix_const = 0; pix_seed = 9'($urandom);
    start_frame();
    for (int r = 0; r < VL; r++) line(HP, 0, 0);
    repeat (3) cyc(0, 0);
    #1;
    tests++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL clean n_writes: got %0d expected %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      tests++;
      if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL clean write[%0d]: got edge=%0d addr=%0d data=%0h expected edge=%0d addr=%0d data=%0h", i, act_q[i].e, act_q[i].a, act_q[i].d, exp_q[i].e, exp_q[i].a, exp_q[i].d); end
    end
    tests++; if (fd_q.size() != exp_fd_q.size()) begin fails++; $display("FAIL clean n_frame_done: got %0d expected %0d", fd_q.size(), exp_fd_q.size()); end
    foreach (exp_fd_q[i]) if (i < fd_q.size()) begin
      tests++; if (fd_q[i] != exp_fd_q[i]) begin fails++; $display("FAIL clean frame_done[%0d]: got edge %0d expected %0d", i, fd_q[i], exp_fd_q[i]); end
    end
    tests++; if (locked !== m_locked) begin fails++; $display("FAIL clean locked: got %b expected %b", locked, m_locked); end
    tests++; if (int'(err_count) != exp_err()) begin fails++; $display("FAIL clean err_count: got %0d expected %0d", err_count, exp_err()); end
  endtask

  task automatic test_const_data();
    clear_queues();
    pix_const = 1;
    start_frame();
    for (int r = 0; r < VL; r++) line(HP, 0, 0);
    repeat (3) cyc(0, 0);
    #1;
    tests++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL const n_writes: got %0d expected %0d", act_q.size(), exp_q.size()); end
    foreach (act_q[i]) begin
      tests++; if (act_q[i].d != 'h1C9) begin fails++; $display("FAIL const data[%0d]: got %0h expected 1c9", i, act_q[i].d); end
      if (i % HP != 0) begin
        tests++; if (act_q[i].e - act_q[i-1].e != SD) begin fails++; $display("FAIL const spacing[%0d]: got %0d expected %0d", i, act_q[i].e - act_q[i-1].e, SD); end
      end
    end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      tests++;
      if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL const write[%0d]: got edge=%0d addr=%0d expected edge=%0d addr=%0d", i, act_q[i].e, act_q[i].a, exp_q[i].e, exp_q[i].a); end
    end
    tests++; if (fd_q.size() != 1) begin fails++; $display("FAIL const n_frame_done: got %0d expected 1", fd_q.size()); end
    pix_const = 0;
  endtask

  task automatic test_short_line();
    clear_queues();
    pix_seed = 9'($urandom);
    start_frame();
    line(HP, 0, 0);
    line($urandom_range(1, HP - 1), 0, 0);
    line(HP, 0, 0);
    #1;
    tests++; if (locked !== m_locked) begin fails++; $display("FAIL short locked: got %b expected %b", locked, m_locked); end
    tests++; if (int'(err_count) != exp_err()) begin fails++; $display("FAIL short err_count: got %0d expected %0d", err_count, exp_err()); end
    line(HP, 0, 0);
    repeat (3) cyc(0, 0);
    #1;
    tests++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL short n_writes: got %0d expected %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      tests++;
      if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL short write[%0d]: got edge=%0d addr=%0d data=%0h expected edge=%0d addr=%0d data=%0h", i, act_q[i].e, act_q[i].a, act_q[i].d, exp_q[i].e, exp_q[i].a, exp_q[i].d); end
    end
    tests++; if (fd_q.size() != exp_fd_q.size()) begin fails++; $display("FAIL short n_frame_done: got %0d expected %0d", fd_q.size(), exp_fd_q.size()); end
    foreach (exp_fd_q[i]) if (i < fd_q.size()) begin
      tests++; if (fd_q[i] != exp_fd_q[i]) begin fails++; $display("FAIL short frame_done[%0d]: got edge %0d expected %0d", i, fd_q[i], exp_fd_q[i]); end
    end
  endtask

  task automatic test_vsync_abort();
    clear_queues();
    pix_seed = 9'($urandom);
    start_frame();
    line(HP, 0, 0);
    line(HP, 0, 0);
    line(2, 0, 0);
    start_frame();
    #1;
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL vabort locked: got %b expected 0", locked); end
    tests++; if (fd_q.size() != 0) begin fails++; $display("FAIL vabort early frame_done: got %0d pulses expected 0", fd_q.size()); end
    for (int r = 0; r < VL; r++) line(HP, 0, 0);
    repeat (3) cyc(0, 0);
    #1;
    tests++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL vabort n_writes: got %0d expected %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      tests++;
      if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL vabort write[%0d]: got edge=%0d addr=%0d data=%0h expected edge=%0d addr=%0d data=%0h", i, act_q[i].e, act_q[i].a, act_q[i].d, exp_q[i].e, exp_q[i].a, exp_q[i].d); end
    end
    tests++; if (fd_q.size() != exp_fd_q.size()) begin fails++; $display("FAIL vabort n_frame_done: got %0d expected %0d", fd_q.size(), exp_fd_q.size()); end
    tests++; if (int'(err_count) != exp_err()) begin fails++; $display("FAIL vabort err_count: got %0d expected %0d", err_count, exp_err()); end
  endtask

  task automatic test_simul_sync();
    clear_queues();
    pix_seed = 9'($urandom);
    line(HP, 1, 0);
    for (int r = 1; r < VL; r++) line(HP, 0, 0);
    start_frame();
    line(HP, 0, 0);
    line(HP, 1, 0);
    for (int r = 1; r < VL; r++) line(HP, 0, 0);
    repeat (3) cyc(0, 0);
    #1;
    tests++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL simul n_writes: got %0d expected %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      tests++;
      if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL simul write[%0d]: got edge=%0d addr=%0d data=%0h expected edge=%0d addr=%0d data=%0h", i, act_q[i].e, act_q[i].a, act_q[i].d, exp_q[i].e, exp_q[i].a, exp_q[i].d); end
    end
    tests++; if (fd_q.size() != exp_fd_q.size()) begin fails++; $display("FAIL simul n_frame_done: got %0d expected %0d", fd_q.size(), exp_fd_q.size()); end
    foreach (exp_fd_q[i]) if (i < fd_q.size()) begin
      tests++; if (fd_q[i] != exp_fd_q[i]) begin fails++; $display("FAIL simul frame_done[%0d]: got edge %0d expected %0d", i, fd_q[i], exp_fd_q[i]); end
    end
    tests++; if (int'(err_count) != exp_err()) begin fails++; $display("FAIL simul err_count: got %0d expected %0d", err_count, exp_err()); end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    pix_seed = 9'($urandom);
    start_frame();
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < VL; r++) line(HP, 0, (r == VL - 1) && (f < 2));
    repeat (3) cyc(0, 0);
    #1;
    tests++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b n_writes: got %0d expected %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      tests++;
      if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b write[%0d]: got edge=%0d addr=%0d data=%0h expected edge=%0d addr=%0d data=%0h", i, act_q[i].e, act_q[i].a, act_q[i].d, exp_q[i].e, exp_q[i].a, exp_q[i].d); end
    end
    tests++; if (fd_q.size() != exp_fd_q.size()) begin fails++; $display("FAIL b2b n_frame_done: got %0d expected %0d", fd_q.size(), exp_fd_q.size()); end
    foreach (exp_fd_q[i]) if (i < fd_q.size()) begin
      tests++; if (fd_q[i] != exp_fd_q[i]) begin fails++; $display("FAIL b2b frame_done[%0d]: got edge %0d expected %0d", i, fd_q[i], exp_fd_q[i]); end
    end
    tests++; if (locked !== m_locked) begin fails++; $display("FAIL b2b locked: got %b expected %b", locked, m_locked); end
    tests++; if (int'(err_count) != exp_err()) begin fails++; $display("FAIL b2b err_count: got %0d expected %0d", err_count, exp_err()); end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    pix_seed = 9'($urandom);
    start_frame();
    line(2, 0, 0);
    #2;
    rst_n = 1'b0;
    m_in_frame = 0; m_locked = 0; m_err = 0; m_row = 0; m_pending_short = 0;
    #1;
    tests++; if (wr_en !== 1'b0)      begin fails++; $display("FAIL rstmid wr_en: got %b expected 0", wr_en); end
    tests++; if (wr_addr !== '0)      begin fails++; $display("FAIL rstmid wr_addr: got %0d expected 0", wr_addr); end
    tests++; if (wr_data !== '0)      begin fails++; $display("FAIL rstmid wr_data: got %0h expected 0", wr_data); end
    tests++; if (locked !== 1'b0)     begin fails++; $display("FAIL rstmid locked: got %b expected 0", locked); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rstmid frame_done: got %b expected 0", frame_done); end
    tests++; if (err_count !== 8'd0)  begin fails++; $display("FAIL rstmid err_count: got %0d expected 0", err_count); end
    repeat (2) cyc(0, 0);
    rst_n = 1'b1;
    line(HP, 0, 0);
    line(HP, 0, 0);
    start_frame();
    for (int r = 0; r < VL; r++) line(HP, 0, 0);
    repeat (3) cyc(0, 0);
    #1;
    tests++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL rstmid n_writes: got %0d expected %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      tests++;
      if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL rstmid write[%0d]: got edge=%0d addr=%0d data=%0h expected edge=%0d addr=%0d data=%0h", i, act_q[i].e, act_q[i].a, act_q[i].d, exp_q[i].e, exp_q[i].a, exp_q[i].d); end
    end
    tests++; if (fd_q.size() != exp_fd_q.size()) begin fails++; $display("FAIL rstmid n_frame_done: got %0d expected %0d", fd_q.size(), exp_fd_q.size()); end
    tests++; if (locked !== m_locked) begin fails++; $display("FAIL rstmid final locked: got %b expected %b", locked, m_locked); end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_const_data();
    test_short_line();
    test_vsync_abort();
    test_simul_sync();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
